i2c_register_bridge: RTL and testbench



---
 rtl/i2c_bridge_pkg.sv | 20 ++
 rtl/i2c_line_filter.sv | 49 ++++
 rtl/i2c_register_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_register_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bridge_pkg.sv
// Shared types for the I2C register bridge: protocol states and R/W bit values.
package i2c_bridge_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StRegAddr,
    StRegAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } I2cState;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw bus line: 2-FF synchronizer, FILT_LEN-sample glitch filter,
// and single-cycle rise/fall pulses aligned with the filtered level change.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4  // 2..15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync2_q;
  logic       level_q, rise_q, fall_q;
  logic [3:0] cnt_q;

  // Synchronize, then flip the level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_q == 4'(FILT_LEN - 1)) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= 4'd0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_register_bridge.sv
// I2C slave protocol layer feeding a parallel 8-bit register port: device address
// match, register pointer with auto-increment, write strobes and read-data shifting.
module i2c_register_bridge
  import i2c_bridge_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h3D,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned SDA_HOLD = 3   // >= 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] addr,
  output logic [7:0] dataIn,
  output logic       writeEn,
  input  logic [7:0] dataOut,
  output logic       busy
);

  localparam int unsigned HoldW = (SDA_HOLD < 2) ? 1 : $clog2(SDA_HOLD + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  I2cState          state_q;
  logic [2:0]       bit_cnt_q;
  logic [1:0]       ack_phase_q;  // ack states: 0 wait 8th fall, 1 wait 9th edge, 2 wait 9th fall
  logic             rw_q;
  logic [7:0]       shift_q;
  logic [7:0]       addr_q;
  logic [7:0]       data_in_q;
  logic             write_en_q;
  logic             busy_q;
  logic             sda_oe_q;
  logic             sda_pend_q;
  logic [HoldW-1:0] hold_cnt_q;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  // Protocol FSM; SDA drive changes are queued at SCL falls and applied SDA_HOLD clks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      ack_phase_q <= 2'd0;
      rw_q        <= I2C_WRITE;
      shift_q     <= 8'h00;
      addr_q      <= 8'h00;
      data_in_q   <= 8'h00;
      write_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      sda_pend_q  <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      write_en_q <= 1'b0;
      if (hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HoldW'(1);
        if (hold_cnt_q == HoldW'(1)) sda_oe_q <= sda_pend_q;
      end

      // Bus conditions win over any bit event in the same cycle.
      if (stop_det) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        sda_oe_q   <= 1'b0;
        hold_cnt_q <= '0;
        bit_cnt_q  <= 3'd0;
      end else if (start_det) begin
        state_q     <= StDevAddr;
        sda_oe_q    <= 1'b0;
        hold_cnt_q  <= '0;
        bit_cnt_q   <= 3'd0;
        ack_phase_q <= 2'd0;
      end else begin
        case (state_q)
          StDevAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_phase_q <= 2'd0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_q <= StDevAck;
                  busy_q  <= 1'b1;
                  rw_q    <= rx_byte[0];
                end else begin
                  state_q <= StIgnore;
                  busy_q  <= 1'b0;
                end
              end
            end
          end

          StRegAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q      <= rx_byte;
                ack_phase_q <= 2'd0;
                state_q     <= StRegAck;
              end
            end
          end

          StWrData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                data_in_q   <= rx_byte;
                write_en_q  <= 1'b1;
                ack_phase_q <= 2'd0;
                state_q     <= StWrAck;
              end
            end
          end

          StDevAck, StRegAck, StWrAck: begin
            if (scl_fall) begin
              hold_cnt_q <= HoldW'(SDA_HOLD);
              if (ack_phase_q == 2'd0) begin
                sda_pend_q  <= 1'b1;
                ack_phase_q <= 2'd1;
              end else begin
                ack_phase_q <= 2'd0;
                sda_pend_q  <= 1'b0;
                if (state_q == StDevAck) begin
                  if (rw_q == I2C_READ) begin
                    shift_q    <= dataOut;
                    sda_pend_q <= ~dataOut[7];
                    state_q    <= StRdData;
                  end else begin
                    state_q <= StRegAddr;
                  end
                end else if (state_q == StRegAck) begin
                  state_q <= StWrData;
                end else begin
                  addr_q  <= addr_q + 8'd1;
                  state_q <= StWrData;
                end
              end
            end
          end

          StRdData: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_phase_q <= 2'd0;
                state_q     <= StRdAck;
              end
            end else if (scl_fall) begin
              shift_q    <= {shift_q[6:0], 1'b0};
              sda_pend_q <= ~shift_q[6];
              hold_cnt_q <= HoldW'(SDA_HOLD);
            end
          end

          StRdAck: begin
            if (ack_phase_q == 2'd0 && scl_fall) begin
              sda_pend_q  <= 1'b0;
              hold_cnt_q  <= HoldW'(SDA_HOLD);
              ack_phase_q <= 2'd1;
            end else if (ack_phase_q == 2'd1 && scl_rise) begin
              // The pointer steps past every byte clocked out, so a NACKed final read
              // still leaves it one beyond the last byte transferred.
              addr_q <= addr_q + 8'd1;
              if (!sda_lvl) ack_phase_q <= 2'd2;
              else          state_q     <= StIgnore;
            end else if (ack_phase_q == 2'd2 && scl_fall) begin
              shift_q     <= dataOut;
              sda_pend_q  <= ~dataOut[7];
              hold_cnt_q  <= HoldW'(SDA_HOLD);
              bit_cnt_q   <= 3'd0;
              ack_phase_q <= 2'd0;
              state_q     <= StRdData;
            end
          end

          StIdle, StIgnore: ;

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Reset releases SDA without waiting for the flop to settle.
  assign sda_oe  = sda_oe_q & reset_n;
  assign addr    = addr_q;
  assign dataIn  = data_in_q;
  assign writeEn = write_en_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_register_bridge.sv
// Self-checking bench: bit-banged I2C master, register-file model on dataOut,
// write scoreboard on writeEn and read scoreboard on bytes shifted out on SDA.
module tb_i2c_register_bridge;

  localparam int Q = 25;  // quarter SCL period in clk cycles

  typedef struct {
    logic [6:0] dev;
    logic [7:0] reg_a;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic       exp_busy;
    logic [7:0] exp_addr;
  } wr_vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, writeEn, busy;
  logic [7:0] addr, dataIn;
  logic [7:0] dataOut = 8'h00;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int viol = 0;
  logic prev_oe = 1'b0;
  logic [15:0] wexp;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_register_bridge #(
    .DEV_ADDR (7'h3D),
    .FILT_LEN (4),
    .SDA_HOLD (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .addr    (addr),
    .dataIn  (dataIn),
    .writeEn (writeEn),
    .dataOut (dataOut),
    .busy    (busy)
  );

  function automatic logic [7:0] model(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // Register file read port: one clk of latency after addr.
  always @(posedge clk) dataOut <= model(addr);

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Write scoreboard.
  always @(negedge clk) begin
    if (reset_n && writeEn) begin
      pulses++;
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_writeEn: got addr=%0h data=%0h expected no write", addr, dataIn);
      end else begin
        wexp = wq.pop_front();
        check("write_addr_data", {addr, dataIn}, wexp);
      end
    end
  end

  // SDA drive must not move while SCL is high in any of these sequences.
  always @(negedge clk) begin
    if (reset_n && scl_m && (sda_oe != prev_oe)) viol++;
    prev_oe = sda_oe;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wclk(Q);
    scl_m = 1'b1; wclk(2 * Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    b = sda_line; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  // Bit with a 2-clk SCL low glitch and a 2-clk SDA glitch inside the high phase.
  task automatic glitch_bit(input logic b);
    sda_m = b; wclk(Q);
    scl_m = 1'b1; wclk(8);
    scl_m = 1'b0; wclk(2);
    scl_m = 1'b1; wclk(5);
    sda_m = ~b; wclk(2);
    sda_m = b; wclk(2 * Q - 17);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic glitch_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) glitch_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    wr_vec_t    vecs[4];
    logic       a0, a1, a2, a3;
    logic [7:0] rb, re, nxt;

    vecs[0] = '{dev: 7'h3D, reg_a: 8'h82, d0: 8'h05, d1: 8'h07,
                exp_ack: 1'b1, exp_busy: 1'b1, exp_addr: 8'h84};
    vecs[1] = '{dev: 7'h3D, reg_a: 8'hFF, d0: 8'hAA, d1: 8'hBB,
                exp_ack: 1'b1, exp_busy: 1'b1, exp_addr: 8'h01};
    vecs[2] = '{dev: 7'h50, reg_a: 8'h12, d0: 8'h34, d1: 8'h56,
                exp_ack: 1'b0, exp_busy: 1'b0, exp_addr: 8'h01};
    vecs[3] = '{dev: 7'h3D, reg_a: 8'h10, d0: 8'h01, d1: 8'h02,
                exp_ack: 1'b1, exp_busy: 1'b1, exp_addr: 8'h12};

    wclk(3);
    check("reset_sda_oe", {15'd0, sda_oe}, 16'd0);
    check("reset_addr", {8'd0, addr}, 16'h00);
    check("reset_dataIn", {8'd0, dataIn}, 16'h00);
    check("reset_writeEn", {15'd0, writeEn}, 16'd0);
    check("reset_busy", {15'd0, busy}, 16'd0);
    reset_n = 1'b1;
    wclk(10);

    // Table of write transactions: device, register, two data bytes.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].exp_ack) begin
        nxt = vecs[i].reg_a + 8'd1;
        wq.push_back({vecs[i].reg_a, vecs[i].d0});
        wq.push_back({nxt, vecs[i].d1});
        exp_pulses += 2;
      end
      i2c_start;
      write_byte({vecs[i].dev, 1'b0}, a0);
      write_byte(vecs[i].reg_a, a1);
      write_byte(vecs[i].d0, a2);
      check($sformatf("vec%0d_busy_mid", i), {15'd0, busy}, {15'd0, vecs[i].exp_busy});
      write_byte(vecs[i].d1, a3);
      i2c_stop;
      wclk(10);
      check($sformatf("vec%0d_ack_dev", i), {15'd0, a0}, {15'd0, ~vecs[i].exp_ack});
      check($sformatf("vec%0d_ack_reg", i), {15'd0, a1}, {15'd0, ~vecs[i].exp_ack});
      check($sformatf("vec%0d_ack_d0", i), {15'd0, a2}, {15'd0, ~vecs[i].exp_ack});
      check($sformatf("vec%0d_ack_d1", i), {15'd0, a3}, {15'd0, ~vecs[i].exp_ack});
      check($sformatf("vec%0d_busy_after_stop", i), {15'd0, busy}, 16'd0);
      check($sformatf("vec%0d_addr_end", i), {8'd0, addr}, {8'd0, vecs[i].exp_addr});
    end

    // Register pointer set, repeated START, three-byte read ACK/ACK/NACK.
    i2c_start;
    write_byte(8'h7A, a0);
    write_byte(8'hB0, a1);
    i2c_start;
    write_byte(8'h7B, a2);
    check("rd_ack_dev_w", {15'd0, a0}, 16'd0);
    check("rd_ack_reg", {15'd0, a1}, 16'd0);
    check("rd_ack_dev_r", {15'd0, a2}, 16'd0);
    for (int k = 0; k < 3; k++) rq.push_back(model(8'hB0 + 8'(k)));
    for (int k = 0; k < 3; k++) begin
      read_byte(k == 2, rb);
      re = rq.pop_front();
      check($sformatf("rd_data%0d", k), {8'd0, rb}, {8'd0, re});
    end
    i2c_stop;
    wclk(10);
    check("rd_addr_end", {8'd0, addr}, 16'h00B3);
    check("rd_busy_after_stop", {15'd0, busy}, 16'd0);

    // STOP in the middle of a data byte: no write, bus released.
    i2c_start;
    write_byte(8'h7A, a0);
    write_byte(8'h40, a1);
    for (int i = 7; i >= 3; i--) write_bit(i[0]);
    i2c_stop;
    wclk(10);
    check("part_ack_dev", {15'd0, a0}, 16'd0);
    check("part_ack_reg", {15'd0, a1}, 16'd0);
    check("part_sda_oe", {15'd0, sda_oe}, 16'd0);
    check("part_busy", {15'd0, busy}, 16'd0);
    check("part_addr", {8'd0, addr}, 16'h0040);

    // Short glitches on SCL and SDA during every SCL high phase.
    wq.push_back(16'h603C);
    exp_pulses++;
    i2c_start;
    glitch_byte(8'h7A, a0);
    glitch_byte(8'h60, a1);
    glitch_byte(8'h3C, a2);
    i2c_stop;
    wclk(10);
    check("glitch_ack_dev", {15'd0, a0}, 16'd0);
    check("glitch_ack_reg", {15'd0, a1}, 16'd0);
    check("glitch_ack_data", {15'd0, a2}, 16'd0);
    check("glitch_addr", {8'd0, addr}, 16'h0061);

    // Asynchronous reset while the slave holds the address ACK.
    i2c_start;
    for (int i = 7; i >= 0; i--) write_bit(rb_bit(8'h7A, i));
    sda_m = 1'b1;
    check("rst_pre_sda_oe", {15'd0, sda_oe}, 16'd1);
    #1 reset_n = 1'b0;
    #1 check("rst_sda_released", {15'd0, sda_oe}, 16'd0);
    wclk(3);
    reset_n = 1'b1;
    check("rst_addr", {8'd0, addr}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    wclk(Q);
    i2c_stop;
    wclk(10);

    check("write_queue_empty", 16'(wq.size()), 16'd0);
    check("writeEn_pulses", 16'(pulses), 16'(exp_pulses));
    check("sda_change_scl_high", 16'(viol), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
